shrimp_writeback: RTL
=====================

SHRIMP_WRITEBACK -- requirements
Module: shrimp_writeback

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clock and reset_n.
REQ-002 clock  input  1  rising-edge clock, shared with shrimp_regfile.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 alu_valid / alu_addr / alu_val  input  1/4/16  single-cycle ALU result, always accepted (no backpressure).
REQ-005 mem_valid / mem_addr / mem_val  input  1/4/16  load result offered by memory unit.
REQ-006 mem_ready  output  1  load result accepted on a rising edge when mem_valid and mem_ready are both 1.
REQ-007 reg_w_enable / reg_w_addr / reg_w_val  output  1/4/16  regfile write port; regfile commits on the rising edge.
REQ-008 rd_a_addr / rd_b_addr  input  4/4  decode-stage source addresses, same values that drive reg_r_a_addr / reg_r_b_addr.
REQ-009 fwd_a_hit, fwd_b_hit  output  1  bypass value valid; fwd_a_val, fwd_b_val  output  16  bypass data.
REQ-010 stall_a, stall_b  output  1  source has an unresolved pending write; decode holds.
REQ-011 pending_count  output  2  number of occupied load-queue slots (0..2).

Function
REQ-012 Load queue: 2-entry FIFO of {valid, addr[3:0], val[15:0]}; push on mem_valid && mem_ready.
REQ-013 mem_ready SHALL be 1 when pending_count < 2 and 0 when pending_count = 2, combinational from registered state only.
REQ-014 Write port priority, combinational each cycle: alu_valid=1 -> enable=1, addr/val = alu; else head slot valid -> enable=1, addr/val = head, head popped on the edge; else enable=0, addr=0, val=0.
REQ-015 A head slot whose valid bit is 0 (killed) SHALL be popped when the ALU is idle, with reg_w_enable=0 that cycle.
REQ-016 Kill rule: when alu_valid=1, every occupied slot with addr = alu_addr SHALL have its valid bit cleared on that edge; a same-cycle push with mem_addr = alu_addr is NOT killed.
REQ-017 Simultaneous push and pop SHALL leave pending_count unchanged; FIFO pointers SHALL wrap modulo 2.
REQ-018 Writes to address 0 SHALL be treated like any other address; no register is hard-wired.
REQ-019 Lookup for each of A and B SHALL check, newest first: (1) alu_valid with alu_addr match, (2) the newest valid queue slot with a matching address.
REQ-020 Slots that are occupied but killed SHALL never produce a lookup hit.
REQ-021 A write being presented on the port in the current cycle still counts as a hit, because the regfile read reflects it only after the edge.
REQ-022 Latency: an accepted load reaches reg_w_enable no earlier than the cycle after acceptance; an ALU result writes the same cycle it is presented.

Reset
REQ-023 While reset_n = 0, all slots SHALL be cleared, pointers zeroed, and pending_count = 0.
REQ-024 While reset_n = 0, mem_ready SHALL be 0.
REQ-025 While reset_n = 0, reg_w_enable, fwd_*_hit, and stall_* SHALL be 0, and all data outputs SHALL be 0, regardless of other inputs.
REQ-026 Reset asserted mid-operation SHALL discard pending loads without issuing any write.
REQ-027 mem_ready SHALL rise in the first cycle after reset_n deasserts.

Configuration
REQ-028 Macro SHRIMP_WB_FWD_EN defined: on a lookup hit, fwd_x_hit=1 and fwd_x_val = the matched value, and stall_x=0.
REQ-029 Macro SHRIMP_WB_FWD_EN undefined: fwd_x_hit=0, fwd_x_val=0, and stall_x=1 on any lookup hit.
REQ-030 Ports SHALL be identical with and without SHRIMP_WB_FWD_EN.

Verification
REQ-031 Reset: hold reset_n=0 with alu_valid=1 -> reg_w_enable=0 and mem_ready=0; release reset_n -> mem_ready=1 and pending_count=0.
REQ-032 Load path: push mem addr 0x0, val 120, ALU idle -> next cycle reg_w_enable=1, addr 0x0, val 120; regfile reg0 reads 120 after the edge.
REQ-033 Full and priority: push loads to 0x1 (val 5) and 0x2 (val 6) while alu_valid writes 0xF (val 240) for 3 cycles -> pending_count=2, mem_ready=0, and only 0xF is written; then ALU idle -> 0x1=5 and 0x2=6 are written in order.
REQ-034 Kill: pending load to 0x3 (val 9), then ALU writes 0x3 (val 7) -> slot killed, drained with reg_w_enable=0, and reg3 ends at 7.
REQ-035 Forwarding, with SHRIMP_WB_FWD_EN: slots 0x4=10 and 0x4=11 pending, rd_a_addr=0x4 -> fwd_a_hit=1, fwd_a_val=11, stall_a=0; additionally alu_valid with 0x4=12 -> fwd_a_val=12.
REQ-036 No forwarding, without SHRIMP_WB_FWD_EN: same stimulus as REQ-035 -> stall_a=1 and fwd_a_hit=0 until the queue drains, then stall_a=0.

Source files
------------

// File: rtl/shrimp_writeback_if.sv
// Bundle of the writeback-stage signals: ALU result, load-result handshake,
// regfile write port, decode lookups and bypass/stall answers.
interface shrimp_writeback_if;
  // The load handshake is valid/ready. A transfer happens on a rising edge
  // where mem_valid and mem_ready are both 1. While mem_valid is high without
  // that transfer, the producer holds mem_addr and mem_val steady.
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_val;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_val;
  logic        mem_ready;
  logic        reg_w_enable;
  logic [3:0]  reg_w_addr;
  logic [15:0] reg_w_val;
  logic [3:0]  rd_a_addr;
  logic [3:0]  rd_b_addr;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [15:0] fwd_a_val;
  logic [15:0] fwd_b_val;
  logic        stall_a;
  logic        stall_b;
  logic [1:0]  pending_count;

  modport master (
    output alu_valid, alu_addr, alu_val, mem_valid, mem_addr, mem_val,
           rd_a_addr, rd_b_addr,
    input  mem_ready, reg_w_enable, reg_w_addr, reg_w_val,
           fwd_a_hit, fwd_b_hit, fwd_a_val, fwd_b_val, stall_a, stall_b,
           pending_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_val, mem_valid, mem_addr, mem_val,
           rd_a_addr, rd_b_addr,
    output mem_ready, reg_w_enable, reg_w_addr, reg_w_val,
           fwd_a_hit, fwd_b_hit, fwd_a_val, fwd_b_val, stall_a, stall_b,
           pending_count
  );
endinterface

// File: rtl/shrimp_writeback.sv
// Writeback arbiter: ALU results write immediately, loads wait in a 2-entry queue.
// Optional macro SHRIMP_WB_FWD_EN turns lookup hits into bypass data instead of stalls.
module shrimp_writeback (
  input logic             clock,
  input logic             reset_n,
  shrimp_writeback_if.slave bus
);
  logic [1:0]  slot_occ;
  logic [1:0]  slot_vld;
  logic [3:0]  slot_addr [2];
  logic [15:0] slot_val  [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        newest;
  logic        hit_a;
  logic        hit_b;

  assign bus.pending_count = count;
  assign bus.mem_ready     = reset_n && (count != 2'd2);
  assign push              = bus.mem_valid && bus.mem_ready;
  // A killed head still leaves the queue whenever the ALU leaves the port free.
  assign pop               = !bus.alu_valid && (count != 2'd0);
  assign newest            = (count == 2'd2) ? ~head : head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_occ     <= 2'b00;
      slot_vld     <= 2'b00;
      slot_addr[0] <= 4'd0;
      slot_addr[1] <= 4'd0;
      slot_val[0]  <= 16'd0;
      slot_val[1]  <= 16'd0;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
    end else begin
      // Only slots already occupied are killed; this edge's push lands in a free slot.
      for (int i = 0; i < 2; i++) begin
        if (bus.alu_valid && slot_occ[i] && (slot_addr[i] == bus.alu_addr))
          slot_vld[i] <= 1'b0;
      end
      if (pop) begin
        slot_occ[head] <= 1'b0;
        slot_vld[head] <= 1'b0;
        head           <= ~head;
      end
      if (push) begin
        slot_occ[tail]  <= 1'b1;
        slot_vld[tail]  <= 1'b1;
        slot_addr[tail] <= bus.mem_addr;
        slot_val[tail]  <= bus.mem_val;
        tail            <= ~tail;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    bus.reg_w_enable = 1'b0;
    bus.reg_w_addr   = 4'd0;
    bus.reg_w_val    = 16'd0;
    if (reset_n) begin
      if (bus.alu_valid) begin
        bus.reg_w_enable = 1'b1;
        bus.reg_w_addr   = bus.alu_addr;
        bus.reg_w_val    = bus.alu_val;
      end else if ((count != 2'd0) && slot_vld[head]) begin
        bus.reg_w_enable = 1'b1;
        bus.reg_w_addr   = slot_addr[head];
        bus.reg_w_val    = slot_val[head];
      end
    end
  end

  // Newest first: ALU, then the younger slot, then the head (valid implies occupied).
  function automatic logic lookup_hit(input logic [3:0] a);
    logic h;
    h = 1'b0;
    if (bus.alu_valid && (bus.alu_addr == a))
      h = 1'b1;
    else if ((count != 2'd0) && slot_vld[newest] && (slot_addr[newest] == a))
      h = 1'b1;
    else if ((count == 2'd2) && slot_vld[head] && (slot_addr[head] == a))
      h = 1'b1;
    return h;
  endfunction

  assign hit_a = reset_n && lookup_hit(bus.rd_a_addr);
  assign hit_b = reset_n && lookup_hit(bus.rd_b_addr);

`ifdef SHRIMP_WB_FWD_EN
  function automatic logic [15:0] lookup_val(input logic [3:0] a);
    logic [15:0] v;
    v = 16'd0;
    if (bus.alu_valid && (bus.alu_addr == a))
      v = bus.alu_val;
    else if ((count != 2'd0) && slot_vld[newest] && (slot_addr[newest] == a))
      v = slot_val[newest];
    else if ((count == 2'd2) && slot_vld[head] && (slot_addr[head] == a))
      v = slot_val[head];
    return v;
  endfunction

  always_comb begin
    bus.fwd_a_hit = hit_a;
    bus.fwd_b_hit = hit_b;
    bus.fwd_a_val = hit_a ? lookup_val(bus.rd_a_addr) : 16'd0;
    bus.fwd_b_val = hit_b ? lookup_val(bus.rd_b_addr) : 16'd0;
    bus.stall_a   = 1'b0;
    bus.stall_b   = 1'b0;
  end
`else
  always_comb begin
    bus.fwd_a_hit = 1'b0;
    bus.fwd_b_hit = 1'b0;
    bus.fwd_a_val = 16'd0;
    bus.fwd_b_val = 16'd0;
    bus.stall_a   = hit_a;
    bus.stall_b   = hit_b;
  end
`endif
endmodule
